// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM driving datapath muxes/enables, plus a retired-instruction counter.
// Latency: outputs decoded from state; R/I/SW 4, LW 5, BEQ/BNE/J/JAL 3 cycles, plus one per wait cycle.
// Backpressure: mem_ready low holds FETCH, MEM_RD and MEM_WR; mem_ready is ignored in every other state.
module multicycle_control #(
  parameter int ALUOP_WIDTH = 3,
  parameter int CNT_WIDTH   = 32,
  parameter int ENABLE_JAL  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             op,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   pc_write_cond_eq,
  output logic                   pc_write_cond_ne,
  output logic                   i_or_d,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic [1:0]             mem_to_reg,
  output logic [1:0]             reg_dst,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [ALUOP_WIDTH-1:0] alu_op,
  output logic [1:0]             pc_source,
  output logic                   illegal_op,
  output logic [CNT_WIDTH-1:0]   instr_count,
  output logic [3:0]             state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_TRAP     = 4'd13
  } stateT;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_LUI   = 3'b101;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  stateT                state;
  stateT                nextState;
  logic [CNT_WIDTH-1:0] instrCnt;
  logic                 retire;

  logic       pcWriteS, condEqS, condNeS, iOrDS, memReadS, memWriteS, irWriteS;
  logic [1:0] memToRegS, regDstS, aluSrcBS, pcSourceS;
  logic       regWriteS, aluSrcAS, illegalS;
  logic [2:0] aluOpS;

  // State register: synchronous active-low reset back to FETCH
  always_ff @(posedge clk) begin
    if (!reset) state <= S_FETCH;
    else        state <= nextState;
  end

  // Next-state: sequencing, opcode dispatch in DECODE, wait states on mem_ready
  always_comb begin
    nextState = S_FETCH;
    case (state)
      S_FETCH:    nextState = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_RTYPE:                         nextState = S_EXEC_R;
          OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: nextState = S_EXEC_I;
          OP_LW, OP_SW:                     nextState = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                   nextState = S_BRANCH;
          OP_J:                             nextState = S_JUMP;
          OP_JAL:                           nextState = (ENABLE_JAL != 0) ? S_JAL : S_TRAP;
          default:                          nextState = S_TRAP;
        endcase
      end
      S_MEM_ADDR: nextState = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   nextState = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   nextState = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R:   nextState = S_R_WB;
      S_EXEC_I:   nextState = S_I_WB;
      default:    nextState = S_FETCH;  // write-back, branch, jump, trap and unused codes
    endcase
  end

  // Outputs: Moore decode of state; only the FETCH IR/PC loads look at mem_ready
  always_comb begin
    pcWriteS  = 1'b0;
    condEqS   = 1'b0;
    condNeS   = 1'b0;
    iOrDS     = 1'b0;
    memReadS  = 1'b0;
    memWriteS = 1'b0;
    irWriteS  = 1'b0;
    memToRegS = 2'b00;
    regDstS   = 2'b00;
    regWriteS = 1'b0;
    aluSrcAS  = 1'b0;
    aluSrcBS  = 2'b00;
    aluOpS    = ALU_ADD;
    pcSourceS = 2'b00;
    illegalS  = 1'b0;
    case (state)
      S_FETCH: begin
        memReadS = 1'b1;
        aluSrcBS = 2'b01;
        irWriteS = mem_ready;
        pcWriteS = mem_ready;
      end
      S_DECODE:   aluSrcBS = 2'b11;
      S_MEM_ADDR: begin
        aluSrcAS = 1'b1;
        aluSrcBS = 2'b10;
      end
      S_MEM_RD: begin
        memReadS = 1'b1;
        iOrDS    = 1'b1;
      end
      S_MEM_WB: begin
        memToRegS = 2'b01;
        regWriteS = 1'b1;
      end
      S_MEM_WR: begin
        memWriteS = 1'b1;
        iOrDS     = 1'b1;
      end
      S_EXEC_R: begin
        aluSrcAS = 1'b1;
        aluOpS   = ALU_FUNCT;
      end
      S_R_WB: begin
        regDstS   = 2'b01;
        regWriteS = 1'b1;
      end
      S_EXEC_I: begin
        aluSrcAS = 1'b1;
        aluSrcBS = 2'b10;
        case (op)
          OP_ORI:  aluOpS = ALU_OR;
          OP_ANDI: aluOpS = ALU_AND;
          OP_LUI:  aluOpS = ALU_LUI;
          default: aluOpS = ALU_ADD;
        endcase
      end
      S_I_WB:     regWriteS = 1'b1;
      S_BRANCH: begin
        aluSrcAS  = 1'b1;
        aluOpS    = ALU_SUB;
        pcSourceS = 2'b01;
        condEqS   = (op == OP_BEQ);
        condNeS   = (op == OP_BNE);
      end
      S_JUMP: begin
        pcWriteS  = 1'b1;
        pcSourceS = 2'b10;
      end
      S_JAL: begin
        pcWriteS  = 1'b1;
        pcSourceS = 2'b10;
        regWriteS = 1'b1;
        regDstS   = 2'b10;
        memToRegS = 2'b10;
      end
      S_TRAP:     illegalS = 1'b1;
      default:    aluOpS = ALU_ADD;
    endcase
  end

  // Retire on any entry into FETCH except from FETCH itself or a trapped instruction
  assign retire = (nextState == S_FETCH) && (state != S_FETCH) && (state != S_TRAP);

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (!reset)      instrCnt <= '0;
    else if (retire) instrCnt <= instrCnt + CNT_WIDTH'(1);
  end

  // While reset is held low every strobe is dropped immediately, not at the next edge
  assign pc_write         = reset & pcWriteS;
  assign pc_write_cond_eq = reset & condEqS;
  assign pc_write_cond_ne = reset & condNeS;
  assign i_or_d           = reset & iOrDS;
  assign mem_read         = reset & memReadS;
  assign mem_write        = reset & memWriteS;
  assign ir_write         = reset & irWriteS;
  assign mem_to_reg       = reset ? memToRegS : 2'b00;
  assign reg_dst          = reset ? regDstS : 2'b00;
  assign reg_write        = reset & regWriteS;
  assign alu_src_a        = reset & aluSrcAS;
  assign alu_src_b        = reset ? aluSrcBS : 2'b00;
  assign alu_op           = reset ? ALUOP_WIDTH'(aluOpS) : '0;
  assign pc_source        = reset ? pcSourceS : 2'b00;
  assign illegal_op       = reset & illegalS;
  assign instr_count      = reset ? instrCnt : '0;
  assign state_o          = state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: two DUTs (default; JAL disabled, 4-bit counter, 4-bit alu_op) run in lockstep.
// Latency: expected state sequence built per instruction from its class and wait counts.
// Backpressure: mem_ready driven per cycle; waits placed only in FETCH, MEM_RD and MEM_WR.
module tb_multicycle_control;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_RD = 3, S_MEM_WB = 4,
                 S_MEM_WR = 5, S_EXEC_R = 6, S_R_WB = 7, S_EXEC_I = 8, S_I_WB = 9,
                 S_BRANCH = 10, S_JUMP = 11, S_JAL = 12, S_TRAP = 13;

  typedef struct packed {
    logic       pcWrite;
    logic       condEq;
    logic       condNe;
    logic       iOrD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic [1:0] memToReg;
    logic [1:0] regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic [1:0] pcSource;
    logic       illegal;
  } ctlT;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       memReady;

  always #5 clk = ~clk;

  logic       pcW1, eq1, ne1, iod1, mrd1, mwr1, irw1, rw1, asa1, ill1;
  logic [1:0] m2r1, rdst1, asb1, pcs1;
  logic [2:0] aop1;
  logic [31:0] cnt1;
  logic [3:0] st1;

  logic       pcW2, eq2, ne2, iod2, mrd2, mwr2, irw2, rw2, asa2, ill2;
  logic [1:0] m2r2, rdst2, asb2, pcs2;
  logic [3:0] aop2;
  logic [3:0] cnt2;
  logic [3:0] st2;

  multicycle_control dut1 (
    .clk(clk), .reset(reset), .op(op), .mem_ready(memReady),
    .pc_write(pcW1), .pc_write_cond_eq(eq1), .pc_write_cond_ne(ne1), .i_or_d(iod1),
    .mem_read(mrd1), .mem_write(mwr1), .ir_write(irw1), .mem_to_reg(m2r1), .reg_dst(rdst1),
    .reg_write(rw1), .alu_src_a(asa1), .alu_src_b(asb1), .alu_op(aop1), .pc_source(pcs1),
    .illegal_op(ill1), .instr_count(cnt1), .state_o(st1)
  );

  multicycle_control #(.ALUOP_WIDTH(4), .CNT_WIDTH(4), .ENABLE_JAL(0)) dut2 (
    .clk(clk), .reset(reset), .op(op), .mem_ready(memReady),
    .pc_write(pcW2), .pc_write_cond_eq(eq2), .pc_write_cond_ne(ne2), .i_or_d(iod2),
    .mem_read(mrd2), .mem_write(mwr2), .ir_write(irw2), .mem_to_reg(m2r2), .reg_dst(rdst2),
    .reg_write(rw2), .alu_src_a(asa2), .alu_src_b(asb2), .alu_op(aop2), .pc_source(pcs2),
    .illegal_op(ill2), .instr_count(cnt2), .state_o(st2)
  );

  int     checks = 0;
  int     failures = 0;
  bit     chkEn = 1'b0;
  bit     expReset = 1'b1;
  int     expState1 = S_FETCH;
  int     expState2 = S_FETCH;
  longint expCnt1 = 0;
  longint expCnt2 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t st1=%0d st2=%0d op=%0h)",
               name, act, exp, $time, expState1, expState2, op);
    end
  endtask

  // What every control output must be for a given state, opcode and mem_ready
  function automatic ctlT expOut(input int st, input logic [5:0] opc, input logic mr, input bit rst);
    ctlT c;
    c = '0;
    if (rst) return c;
    case (st)
      S_FETCH:    begin c.memRead = 1; c.aluSrcB = 2'b01; c.irWrite = mr; c.pcWrite = mr; end
      S_DECODE:   c.aluSrcB = 2'b11;
      S_MEM_ADDR: begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
      S_MEM_RD:   begin c.memRead = 1; c.iOrD = 1; end
      S_MEM_WB:   begin c.memToReg = 2'b01; c.regWrite = 1; end
      S_MEM_WR:   begin c.memWrite = 1; c.iOrD = 1; end
      S_EXEC_R:   begin c.aluSrcA = 1; c.aluOp = 3'b111; end
      S_R_WB:     begin c.regDst = 2'b01; c.regWrite = 1; end
      S_EXEC_I: begin
        c.aluSrcA = 1; c.aluSrcB = 2'b10;
        if (opc == 6'h0d)      c.aluOp = 3'b010;
        else if (opc == 6'h0c) c.aluOp = 3'b011;
        else if (opc == 6'h0f) c.aluOp = 3'b101;
      end
      S_I_WB:     c.regWrite = 1;
      S_BRANCH: begin
        c.aluSrcA = 1; c.aluOp = 3'b001; c.pcSource = 2'b01;
        c.condEq = (opc == 6'h04); c.condNe = (opc == 6'h05);
      end
      S_JUMP:     begin c.pcWrite = 1; c.pcSource = 2'b10; end
      S_JAL: begin
        c.pcWrite = 1; c.pcSource = 2'b10; c.regWrite = 1; c.regDst = 2'b10; c.memToReg = 2'b10;
      end
      S_TRAP:     c.illegal = 1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  ctlT         e1, e2;
  logic [20:0] a1;
  logic [21:0] a2;

  // Compare process: every cycle, both DUTs against the model, half a clock after the edge
  always @(negedge clk) begin
    if (chkEn) begin
      e1 = expOut(expState1, op, memReady, expReset);
      e2 = expOut(expState2, op, memReady, expReset);
      a1 = {pcW1, eq1, ne1, iod1, mrd1, mwr1, irw1, m2r1, rdst1, rw1, asa1, asb1, aop1, pcs1, ill1};
      a2 = {aop2[3], pcW2, eq2, ne2, iod2, mrd2, mwr2, irw2, m2r2, rdst2, rw2, asa2, asb2, aop2[2:0],
            pcs2, ill2};
      check("state1", 64'(st1), 64'(expState1));
      check("state2", 64'(st2), 64'(expState2));
      check("ctl1", 64'(a1), 64'(e1));
      check("ctl2", 64'(a2), 64'({1'b0, e2}));
      check("cnt1", 64'(cnt1), expReset ? 64'd0 : 64'(expCnt1 & 64'hFFFF_FFFF));
      check("cnt2", 64'(cnt2), expReset ? 64'd0 : 64'(expCnt2 % 16));
    end
  end

  task automatic step(input int s1, input int s2, input bit mrv);
    memReady  = mrv;
    expState1 = s1;
    expState2 = s2;
    @(posedge clk);
    #2;
  endtask

  // One instruction: state path from opcode class and wait counts, then the retire rule
  task automatic runInstr(input logic [5:0] opc, input int wf, input int wm, output int cyc);
    int seq[$];
    bit mr[$];
    int s2;
    op = opc;
    for (int i = 0; i < wf; i++) begin seq.push_back(S_FETCH); mr.push_back(1'b0); end
    seq.push_back(S_FETCH);  mr.push_back(1'b1);
    seq.push_back(S_DECODE); mr.push_back(1'($urandom_range(0, 1)));
    case (opc)
      6'h00: begin seq.push_back(S_EXEC_R); seq.push_back(S_R_WB); end
      6'h08, 6'h0d, 6'h0c, 6'h0f: begin seq.push_back(S_EXEC_I); seq.push_back(S_I_WB); end
      6'h23, 6'h2b: begin
        seq.push_back(S_MEM_ADDR); mr.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < wm; i++) begin
          seq.push_back(opc == 6'h23 ? S_MEM_RD : S_MEM_WR); mr.push_back(1'b0);
        end
        seq.push_back(opc == 6'h23 ? S_MEM_RD : S_MEM_WR); mr.push_back(1'b1);
        if (opc == 6'h23) seq.push_back(S_MEM_WB);
      end
      6'h04, 6'h05: seq.push_back(S_BRANCH);
      6'h02:        seq.push_back(S_JUMP);
      6'h03:        seq.push_back(S_JAL);
      default:      seq.push_back(S_TRAP);
    endcase
    while (mr.size() < seq.size()) mr.push_back(1'($urandom_range(0, 1)));
    foreach (seq[i]) begin
      s2 = (seq[i] == S_JAL) ? S_TRAP : seq[i];
      step(seq[i], s2, mr[i]);
    end
    if (seq[$] != S_TRAP) expCnt1++;
    if (seq[$] != S_TRAP && seq[$] != S_JAL) expCnt2++;
    expState1 = S_FETCH;
    expState2 = S_FETCH;
    cyc = seq.size();
  endtask

  // Load stalled in MEM_RD, then reset pulled low mid-wait
  task automatic abortLoad();
    op = 6'h23;
    step(S_FETCH, S_FETCH, 1'b1);
    step(S_DECODE, S_DECODE, 1'b1);
    step(S_MEM_ADDR, S_MEM_ADDR, 1'b0);
    step(S_MEM_RD, S_MEM_RD, 1'b0);
    reset    = 1'b0;
    expReset = 1'b1;
    step(S_MEM_RD, S_MEM_RD, 1'b0);
    expCnt1 = 0;
    expCnt2 = 0;
    step(S_FETCH, S_FETCH, 1'b1);
    reset     = 1'b1;
    expReset  = 1'b0;
    expState1 = S_FETCH;
    expState2 = S_FETCH;
  endtask

  int cyc;
  logic [5:0] legalOps [12] = '{6'h00, 6'h08, 6'h0d, 6'h0c, 6'h0f, 6'h23, 6'h2b,
                                6'h04, 6'h05, 6'h02, 6'h03, 6'h3f};

  initial begin
    reset    = 1'b0;
    memReady = 1'b1;
    op       = 6'h00;
    @(posedge clk); #2;
    chkEn = 1'b1;
    @(posedge clk); #2;
    check("rst_state", 64'(st1), 64'd0);
    check("rst_cnt", 64'(cnt1), 64'd0);
    check("rst_memread", 64'(mrd1), 64'd0);
    reset    = 1'b0 | 1'b1;
    expReset = 1'b0;
    #1;
    check("rel_fetch", 64'({mrd1, irw1, pcW1}), 64'b111);

    runInstr(6'h00, 0, 0, cyc);
    check("r_cnt", 64'(cnt1), 64'd1);
    check("r_cyc", 64'(cyc), 64'd4);

    runInstr(6'h23, 0, 2, cyc);
    check("lw_cnt", 64'(cnt1), 64'd2);
    check("lw_cyc", 64'(cyc), 64'd7);

    runInstr(6'h05, 0, 0, cyc);
    runInstr(6'h3f, 1, 0, cyc);
    check("trap_cnt", 64'(cnt1), 64'd3);
    runInstr(6'h03, 0, 0, cyc);
    check("jal_cnt1", 64'(cnt1), 64'd4);
    check("jal_cnt2", 64'(cnt2), 64'd3);

    abortLoad();
    #1;
    check("abort_state", 64'(st1), 64'd0);
    check("abort_cnt", 64'(cnt1), 64'd0);

    for (int i = 0; i < 17; i++) runInstr(6'h02, 0, 0, cyc);
    check("wrap_cnt1", 64'(cnt1), 64'd17);
    check("wrap_cnt2", 64'(cnt2), 64'd1);

    for (int i = 0; i < 200; i++) begin
      logic [5:0] o;
      if ($urandom_range(0, 7) == 0) o = 6'($urandom_range(0, 63));
      else                           o = legalOps[$urandom_range(0, 11)];
      runInstr(o, $urandom_range(0, 1) * $urandom_range(0, 3),
               $urandom_range(0, 1) * $urandom_range(0, 3), cyc);
    end

    chkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
